axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave
Interface
REQ-001 SHALL have parameter S_AXI_ID_WIDTH, default 1, ID width of all channels.
REQ-002 SHALL have parameter S_AXI_ADDR_WIDTH, default 32, byte address width.
REQ-003 SHALL have parameter S_AXI_DATA_WIDTH, default 128, beat width (power of 2, >=32).
REQ-004 SHALL have parameter MEM_WORDS_LOG2, default 12, log2 of memory depth in beats.
REQ-005 SHALL have port S_AXI_ACLK  in  1  single clock, rising edge.
REQ-006 SHALL have port S_AXI_ARESETN  in  1  asynchronous active-low reset.
REQ-007 SHALL have port S_AXI_AWID  in  ID_WIDTH  write burst ID.
REQ-008 SHALL have port S_AXI_AWADDR  in  ADDR_WIDTH  write start byte address.
REQ-009 SHALL have port S_AXI_AWLEN  in  8  beats minus one.
REQ-010 SHALL have port S_AXI_AWVALID  in  1  write address valid.
REQ-011 SHALL have port S_AXI_AWREADY  out  1  write address accept.
REQ-012 SHALL have port S_AXI_WDATA  in  DATA_WIDTH  write beat.
REQ-013 SHALL have port S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
REQ-014 SHALL have port S_AXI_WLAST  in  1  last beat marker (informational).
REQ-015 SHALL have port S_AXI_WVALID  in  1  write data valid.
REQ-016 SHALL have port S_AXI_WREADY  out  1  write data accept.
REQ-017 SHALL have port S_AXI_BID  out  ID_WIDTH  echoed AWID.
REQ-018 SHALL have port S_AXI_BRESP  out  2  always 2'b00 (OKAY).
REQ-019 SHALL have port S_AXI_BVALID  out  1  write response valid.
REQ-020 SHALL have port S_AXI_BREADY  in  1  write response accept.
REQ-021 SHALL have port S_AXI_ARID  in  ID_WIDTH  read burst ID.
REQ-022 SHALL have port S_AXI_ARADDR  in  ADDR_WIDTH  read start byte address.
REQ-023 SHALL have port S_AXI_ARLEN  in  8  beats minus one.
REQ-024 SHALL have port S_AXI_ARVALID  in  1  read address valid.
REQ-025 SHALL have port S_AXI_ARREADY  out  1  read address accept.
REQ-026 SHALL have port S_AXI_RID  out  ID_WIDTH  echoed ARID.
REQ-027 SHALL have port S_AXI_RDATA  out  DATA_WIDTH  read beat.
REQ-028 SHALL have port S_AXI_RRESP  out  2  always 2'b00 (OKAY).
REQ-029 SHALL have port S_AXI_RLAST  out  1  high on final read beat.
REQ-030 SHALL have port S_AXI_RVALID  out  1  read data valid.
REQ-031 SHALL have port S_AXI_RREADY  in  1  read data accept.
Function
REQ-032 SHALL implement INCR bursts only, full-width beats; word index = addr[ADDR_LSB +: MEM_WORDS_LOG2], ADDR_LSB=log2(DATA_WIDTH/8), incrementing by 1 per beat, wrapping modulo 2^MEM_WORDS_LOG2.
REQ-033 Write FSM SHALL be W_IDLE (AWREADY=1, WREADY=0) -> W_DATA on AW handshake (latch ID/addr/len, AWREADY=0) -> W_RESP after beat count == AWLEN -> W_IDLE on BVALID&BREADY.
REQ-034 In W_DATA WREADY SHALL be 1; each WVALID&WREADY writes bytes where WSTRB=1; burst end set by beat counter, WLAST ignored; BVALID asserts cycle after last beat, held until BREADY.
REQ-035 Read FSM SHALL be R_IDLE (ARREADY=1) -> R_DATA on AR handshake -> R_IDLE on last RVALID&RREADY; first RVALID one cycle after AR handshake.
REQ-036 R_DATA SHALL sustain one beat per cycle while RREADY=1; RVALID/RDATA/RLAST held stable while RVALID=1 and RREADY=0; RLAST=1 only on beat ARLEN.
REQ-037 Read and write FSMs SHALL run concurrently on a dual-port array; same-word read and write in one cycle returns old data.
REQ-038 AWLEN/ARLEN=0 SHALL give 1 beat; 255 SHALL give 256 beats (9-bit beat counters).
Reset
REQ-039 Asserting S_AXI_ARESETN low, including mid-burst, SHALL force both FSMs to IDLE, AWREADY=ARREADY=1, WREADY=BVALID=RVALID=RLAST=0, BID=RID=0; memory contents SHALL NOT be reset.
Configuration
REQ-040 With AXI_MEM_SLAVE_THROTTLE_EN defined, a free-running 2-bit counter (reset 0) SHALL force WREADY=0 and block launch of a new read beat when counter==3 (asserted RVALID never dropped); undefined, no throttling.
Structure
REQ-041 Package axi_mem_slave_pkg SHALL hold FSM state enums and OKAY constant; sub-module axi_mem_dpram (1 write port with byte enables, 1 synchronous read port) SHALL hold the array.
Verification
REQ-042 AW addr 0x100 len 3, WDATA 1..4, WSTRB all 1 -> 4 beats accepted, one BVALID, BID=AWID; AR 0x100 len 3 -> RDATA 1,2,3,4, RLAST on 4th only.
REQ-043 Write word 0x0 with WSTRB=0x000F over prior all-ones -> readback low 4 bytes new, rest 0xFF.
REQ-044 AR len 255 with RREADY toggling every other cycle -> 256 beats, no data loss, RVALID never drops without handshake.
REQ-045 Write at last word (index 4095) len 1 -> second beat lands at index 0.
REQ-046 Reset pulse during beat 2 of 8-beat write -> AWREADY=1, WREADY=0, BVALID=0 next cycle; earlier-written beats retained.

Source files
------------

// File: rtl/axi_mem_slave_pkg.sv
// Shared types for the AXI4 burst memory slave: FSM state encodings and response codes.
package axi_mem_slave_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;

endpackage

// File: rtl/axi_mem_dpram.sv
// Dual-port beat array: one byte-enabled write port, one synchronous read port.
// A same-word read and write in one cycle returns the old word.
module axi_mem_dpram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS  = 12
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDR_BITS-1:0]    waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [ADDR_BITS-1:0]    raddr,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_r [2**ADDR_BITS];

  // Byte-lane write; storage is deliberately never reset.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) begin
          mem_r[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register only advances when a new beat is launched, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata <= mem_r[raddr];
    end
  end

endmodule

// File: rtl/axi_mem_slave.sv
// AXI4 INCR-burst memory slave with independent read and write FSMs.
// Optional throttling via AXI_MEM_SLAVE_THROTTLE_EN (stalls WREADY / read launch one cycle in four).
module axi_mem_slave
  import axi_mem_slave_pkg::*;
#(
  parameter int S_AXI_ID_WIDTH   = 1,
  parameter int S_AXI_ADDR_WIDTH = 32,
  parameter int S_AXI_DATA_WIDTH = 128,
  parameter int MEM_WORDS_LOG2   = 12
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESETN,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                    S_AXI_AWLEN,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WLAST,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);

  localparam int ADDR_LSB = $clog2(S_AXI_DATA_WIDTH/8);
  localparam logic [MEM_WORDS_LOG2-1:0] IDX_ONE = MEM_WORDS_LOG2'(1);

  logic throttle_s;

`ifdef AXI_MEM_SLAVE_THROTTLE_EN
  logic [1:0] thr_cnt_r;

  // Free-running throttle phase counter.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      thr_cnt_r <= 2'd0;
    end else begin
      thr_cnt_r <= thr_cnt_r + 2'd1;
    end
  end
  assign throttle_s = (thr_cnt_r == 2'd3);
`else
  assign throttle_s = 1'b0;
`endif

  // WLAST is informational only and high address bits fall outside the array.
  logic unused_inputs_s;
  assign unused_inputs_s = ^{S_AXI_WLAST, S_AXI_AWADDR, S_AXI_ARADDR};

  // ---------------- write channel ----------------
  w_state_t                  w_state_r;
  logic                      awready_r, wready_r, bvalid_r;
  logic [S_AXI_ID_WIDTH-1:0] bid_r;
  logic [MEM_WORDS_LOG2-1:0] w_addr_r;
  logic [7:0]                w_len_r;
  logic [8:0]                w_cnt_r;
  logic                      aw_hs_s, wready_s, w_hs_s, w_last_s;

  assign aw_hs_s  = S_AXI_AWVALID & awready_r;
  assign wready_s = wready_r & ~throttle_s;
  assign w_hs_s   = S_AXI_WVALID & wready_s;
  assign w_last_s = (w_cnt_r == {1'b0, w_len_r});

  // Write FSM: burst length is governed by the beat counter, never by WLAST.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      w_state_r <= W_IDLE;
      awready_r <= 1'b1;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bid_r     <= '0;
      w_addr_r  <= '0;
      w_len_r   <= 8'd0;
      w_cnt_r   <= 9'd0;
    end else begin
      case (w_state_r)
        W_IDLE: begin
          if (aw_hs_s) begin
            bid_r     <= S_AXI_AWID;
            w_addr_r  <= S_AXI_AWADDR[ADDR_LSB +: MEM_WORDS_LOG2];
            w_len_r   <= S_AXI_AWLEN;
            w_cnt_r   <= 9'd0;
            awready_r <= 1'b0;
            wready_r  <= 1'b1;
            w_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs_s) begin
            w_addr_r <= w_addr_r + IDX_ONE;
            if (w_last_s) begin
              wready_r  <= 1'b0;
              bvalid_r  <= 1'b1;
              w_state_r <= W_RESP;
            end else begin
              w_cnt_r <= w_cnt_r + 9'd1;
            end
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            bvalid_r  <= 1'b0;
            awready_r <= 1'b1;
            w_state_r <= W_IDLE;
          end
        end
        default: begin
          w_state_r <= W_IDLE;
          awready_r <= 1'b1;
          wready_r  <= 1'b0;
          bvalid_r  <= 1'b0;
        end
      endcase
    end
  end

  // ---------------- read channel ----------------
  r_state_t                  r_state_r;
  logic                      arready_r, rvalid_r, rlast_r;
  logic [S_AXI_ID_WIDTH-1:0] rid_r;
  logic [MEM_WORDS_LOG2-1:0] r_addr_r;
  logic [7:0]                r_len_r;
  logic [8:0]                r_cnt_r;
  logic                      ar_hs_s, r_launch_s, launch_last_s;
  logic [MEM_WORDS_LOG2-1:0] rd_idx_s;
  logic [8:0]                beat_s;
  logic [7:0]                len_s;

  assign ar_hs_s       = S_AXI_ARVALID & arready_r;
  assign launch_last_s = (beat_s == {1'b0, len_s});

  // Launch a beat when the output slot frees up; r_cnt_r counts beats already launched.
  always_comb begin
    rd_idx_s   = r_addr_r;
    beat_s     = r_cnt_r;
    len_s      = r_len_r;
    r_launch_s = 1'b0;
    if (ar_hs_s) begin
      rd_idx_s   = S_AXI_ARADDR[ADDR_LSB +: MEM_WORDS_LOG2];
      beat_s     = 9'd0;
      len_s      = S_AXI_ARLEN;
      r_launch_s = ~throttle_s;
    end else if (r_state_r == R_DATA) begin
      r_launch_s = (~rvalid_r | S_AXI_RREADY) & (r_cnt_r <= {1'b0, r_len_r}) & ~throttle_s;
    end else begin
      r_launch_s = 1'b0;
    end
  end

  // Read FSM with registered RVALID/RLAST.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b1;
      rvalid_r  <= 1'b0;
      rlast_r   <= 1'b0;
      rid_r     <= '0;
      r_addr_r  <= '0;
      r_len_r   <= 8'd0;
      r_cnt_r   <= 9'd0;
    end else begin
      case (r_state_r)
        R_IDLE: begin
          if (ar_hs_s) begin
            rid_r     <= S_AXI_ARID;
            r_len_r   <= S_AXI_ARLEN;
            arready_r <= 1'b0;
            r_state_r <= R_DATA;
            if (r_launch_s) begin
              r_addr_r <= rd_idx_s + IDX_ONE;
              r_cnt_r  <= beat_s + 9'd1;
              rvalid_r <= 1'b1;
              rlast_r  <= launch_last_s;
            end else begin
              r_addr_r <= rd_idx_s;
              r_cnt_r  <= 9'd0;
            end
          end
        end
        R_DATA: begin
          if (r_launch_s) begin
            r_addr_r <= rd_idx_s + IDX_ONE;
            r_cnt_r  <= beat_s + 9'd1;
            rvalid_r <= 1'b1;
            rlast_r  <= launch_last_s;
          end else if (rvalid_r && S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
            rlast_r  <= 1'b0;
            if (rlast_r) begin
              arready_r <= 1'b1;
              r_state_r <= R_IDLE;
            end
          end
        end
        default: begin
          r_state_r <= R_IDLE;
          arready_r <= 1'b1;
          rvalid_r  <= 1'b0;
          rlast_r   <= 1'b0;
        end
      endcase
    end
  end

  axi_mem_dpram #(
    .DATA_WIDTH (S_AXI_DATA_WIDTH),
    .ADDR_BITS  (MEM_WORDS_LOG2)
  ) u_dpram (
    .clk   (S_AXI_ACLK),
    .we    (w_hs_s),
    .waddr (w_addr_r),
    .wdata (S_AXI_WDATA),
    .wstrb (S_AXI_WSTRB),
    .re    (r_launch_s),
    .raddr (rd_idx_s),
    .rdata (S_AXI_RDATA)
  );

  assign S_AXI_AWREADY = awready_r;
  assign S_AXI_WREADY  = wready_s;
  assign S_AXI_BID     = bid_r;
  assign S_AXI_BRESP   = RESP_OKAY;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_ARREADY = arready_r;
  assign S_AXI_RID     = rid_r;
  assign S_AXI_RRESP   = RESP_OKAY;
  assign S_AXI_RLAST   = rlast_r;
  assign S_AXI_RVALID  = rvalid_r;

endmodule

// File: tb/tb_axi_mem_slave.sv
// Self-checking bench for axi_mem_slave: directed bursts plus random traffic against a flat memory model.
module tb_axi_mem_slave;

  localparam int DW    = 128;
  localparam int SW    = DW/8;
  localparam int DEPTH = 4096;

  logic          S_AXI_ACLK = 1'b0;
  logic          S_AXI_ARESETN;
  logic [0:0]    S_AXI_AWID;
  logic [31:0]   S_AXI_AWADDR;
  logic [7:0]    S_AXI_AWLEN;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [DW-1:0] S_AXI_WDATA;
  logic [SW-1:0] S_AXI_WSTRB;
  logic          S_AXI_WLAST;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [0:0]    S_AXI_BID;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [0:0]    S_AXI_ARID;
  logic [31:0]   S_AXI_ARADDR;
  logic [7:0]    S_AXI_ARLEN;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [0:0]    S_AXI_RID;
  logic [DW-1:0] S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RLAST;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  always #5 S_AXI_ACLK = ~S_AXI_ACLK;

  axi_mem_slave dut (
    .S_AXI_ACLK    (S_AXI_ACLK),
    .S_AXI_ARESETN (S_AXI_ARESETN),
    .S_AXI_AWID    (S_AXI_AWID),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWLEN   (S_AXI_AWLEN),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WLAST   (S_AXI_WLAST),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BID     (S_AXI_BID),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARID    (S_AXI_ARID),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARLEN   (S_AXI_ARLEN),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RID     (S_AXI_RID),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RLAST   (S_AXI_RLAST),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY)
  );

  // Reference memory: one full-width word per beat index.
  logic [DW-1:0] mem_m [DEPTH];
  int checks = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge S_AXI_ACLK);
    #1;
  endtask

  function automatic logic [DW-1:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  function automatic void model_wr(input int idx, input logic [DW-1:0] d, input logic [SW-1:0] s);
    for (int k = 0; k < SW; k++) begin
      if (s[k]) mem_m[idx % DEPTH][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  task automatic aw_send(input logic [0:0] id, input int idx, input int len);
    int  n;
    bit  hs;
    n = 0;
    S_AXI_AWID    = id;
    S_AXI_AWADDR  = 32'(idx) << 4;
    S_AXI_AWLEN   = 8'(len);
    S_AXI_AWVALID = 1'b1;
    do begin
      hs = S_AXI_AWREADY;
      step();
      n++;
    end while (!hs && n < 100);
    S_AXI_AWVALID = 1'b0;
    chk("aw_handshake", 128'(hs), 128'(1));
  endtask

  task automatic w_beat(input logic [DW-1:0] d, input logic [SW-1:0] s, input bit last, input int gap);
    int n;
    bit hs;
    n = 0;
    repeat (gap) step();
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    S_AXI_WLAST  = last;
    S_AXI_WVALID = 1'b1;
    do begin
      hs = S_AXI_WREADY;
      step();
      n++;
    end while (!hs && n < 100);
    S_AXI_WVALID = 1'b0;
    S_AXI_WLAST  = 1'b0;
    chk("w_handshake", 128'(hs), 128'(1));
  endtask

  // dmode: 0 random, 1 counting from 1, 2 all ones; smode: 0 full, 1 random, 2 low four bytes
  task automatic do_write(input logic [0:0] id, input int idx, input int len,
                          input int dmode, input int smode, input bit gaps);
    logic [DW-1:0] d;
    logic [SW-1:0] s;
    int            hold;
    aw_send(id, idx, len);
    for (int b = 0; b <= len; b++) begin
      d = (dmode == 1) ? DW'(b + 1) : (dmode == 2) ? {DW{1'b1}} : rnd128();
      s = (smode == 1) ? SW'($urandom()) : (smode == 2) ? 16'h000F : 16'hFFFF;
      w_beat(d, s, (b == len), gaps ? int'($urandom_range(0, 2)) : 0);
      model_wr(idx + b, d, s);
    end
    chk("bvalid_after_last", 128'(S_AXI_BVALID), 128'(1));
    chk("bid", 128'(S_AXI_BID), 128'(id));
    chk("bresp", 128'(S_AXI_BRESP), 128'(0));
    chk("wready_in_resp", 128'(S_AXI_WREADY), 128'(0));
    hold = $urandom_range(0, 2);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bvalid_hold", 128'(S_AXI_BVALID), 128'(1));
    end
    S_AXI_BREADY = 1'b1;
    step();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", 128'(S_AXI_BVALID), 128'(0));
    chk("awready_idle", 128'(S_AXI_AWREADY), 128'(1));
  endtask

  // mode: 0 RREADY always high, 1 toggles every other cycle, 2 random
  task automatic do_read(input logic [0:0] id, input int idx, input int len, input int mode);
    int            n, b;
    bit            hs, pend;
    logic [DW-1:0] prev_d;
    n = 0;
    S_AXI_ARID    = id;
    S_AXI_ARADDR  = 32'(idx) << 4;
    S_AXI_ARLEN   = 8'(len);
    S_AXI_ARVALID = 1'b1;
    do begin
      hs = S_AXI_ARREADY;
      step();
      n++;
    end while (!hs && n < 100);
    S_AXI_ARVALID = 1'b0;
    chk("ar_handshake", 128'(hs), 128'(1));
`ifndef AXI_MEM_SLAVE_THROTTLE_EN
    chk("rvalid_first", 128'(S_AXI_RVALID), 128'(1));
`endif
    b = 0;
    n = 0;
    pend = 1'b0;
    prev_d = '0;
    while (b <= len && n < 3000) begin
      S_AXI_RREADY = (mode == 0) ? 1'b1 : (mode == 1) ? ((n % 2) == 0) : 1'($urandom_range(0, 1));
      if (pend) begin
        chk("rvalid_hold", 128'(S_AXI_RVALID), 128'(1));
        chk("rdata_hold", S_AXI_RDATA, prev_d);
      end
      if (S_AXI_RVALID) begin
        chk("rdata", S_AXI_RDATA, mem_m[(idx + b) % DEPTH]);
        chk("rlast", 128'(S_AXI_RLAST), 128'(b == len));
        chk("rid", 128'(S_AXI_RID), 128'(id));
        chk("rresp", 128'(S_AXI_RRESP), 128'(0));
      end
`ifndef AXI_MEM_SLAVE_THROTTLE_EN
      if (mode == 0) chk("rvalid_sustain", 128'(S_AXI_RVALID), 128'(1));
`endif
      hs     = S_AXI_RVALID && S_AXI_RREADY;
      pend   = S_AXI_RVALID && !S_AXI_RREADY;
      prev_d = S_AXI_RDATA;
      step();
      n++;
      if (hs) b++;
    end
    S_AXI_RREADY = 1'b0;
    chk("read_beats", 128'(b), 128'(len + 1));
    chk("rvalid_idle", 128'(S_AXI_RVALID), 128'(0));
    chk("arready_idle", 128'(S_AXI_ARREADY), 128'(1));
  endtask

  initial begin
    int            idx, len;
    logic [DW-1:0] d;

    S_AXI_ARESETN = 1'b0;
    S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b0;
    S_AXI_ARID = '0; S_AXI_ARADDR = '0; S_AXI_ARLEN = '0; S_AXI_ARVALID = 1'b0;
    S_AXI_RREADY = 1'b0;
    step();
    step();
    chk("rst_awready", 128'(S_AXI_AWREADY), 128'(1));
    chk("rst_arready", 128'(S_AXI_ARREADY), 128'(1));
    chk("rst_wready", 128'(S_AXI_WREADY), 128'(0));
    chk("rst_bvalid", 128'(S_AXI_BVALID), 128'(0));
    chk("rst_rvalid", 128'(S_AXI_RVALID), 128'(0));
    chk("rst_rlast", 128'(S_AXI_RLAST), 128'(0));
    chk("rst_bid", 128'(S_AXI_BID), 128'(0));
    chk("rst_rid", 128'(S_AXI_RID), 128'(0));
    S_AXI_ARESETN = 1'b1;
    step();

    // Address 0x100, four counting beats, read back in order.
    do_write(1'b1, 16, 3, 1, 0, 1'b0);
    do_read(1'b1, 16, 3, 0);
    chk("rdata_known_beat", mem_m[19], DW'(4));

    // Partial strobe over an all-ones word.
    do_write(1'b0, 0, 0, 2, 0, 1'b0);
    do_write(1'b0, 0, 0, 0, 2, 1'b0);
    chk("partial_upper_ff", 128'(mem_m[0][DW-1:32]), {32'd0, {96{1'b1}}});
    do_read(1'b0, 0, 0, 0);

    // Burst across the top of the array wraps to index 0.
    do_write(1'b1, 4095, 1, 0, 0, 1'b1);
    do_read(1'b1, 4095, 1, 2);
    do_read(1'b0, 0, 0, 0);

    // 256-beat burst with a back-pressured reader.
    do_write(1'b0, 1000, 255, 0, 0, 1'b0);
    do_read(1'b1, 1000, 255, 1);

    // Random partial overwrites and reads inside the initialised region.
    for (int t = 0; t < 6; t++) begin
      idx = 1000 + $urandom_range(0, 200);
      len = $urandom_range(0, 15);
      do_write(1'(t), idx, len, 0, 1, 1'b1);
      do_read(1'(t + 1), 1000 + $urandom_range(0, 240), $urandom_range(0, 15), $urandom_range(0, 2));
    end

    // Reader and writer active at the same time on disjoint regions.
    fork
      do_write(1'b0, 1010, 20, 0, 1, 1'b1);
      do_read(1'b1, 1100, 30, 2);
    join

    // Reset during the third beat of an eight-beat write.
    aw_send(1'b1, 200, 7);
    for (int b = 0; b < 2; b++) begin
      d = rnd128();
      w_beat(d, 16'hFFFF, 1'b0, 0);
      model_wr(200 + b, d, 16'hFFFF);
    end
    S_AXI_WDATA   = rnd128();
    S_AXI_WSTRB   = 16'hFFFF;
    S_AXI_WVALID  = 1'b1;
    S_AXI_ARESETN = 1'b0;
    step();
    S_AXI_WVALID = 1'b0;
    chk("midrst_awready", 128'(S_AXI_AWREADY), 128'(1));
    chk("midrst_wready", 128'(S_AXI_WREADY), 128'(0));
    chk("midrst_bvalid", 128'(S_AXI_BVALID), 128'(0));
    chk("midrst_bid", 128'(S_AXI_BID), 128'(0));
    chk("midrst_rid", 128'(S_AXI_RID), 128'(0));
    S_AXI_ARESETN = 1'b1;
    step();
    do_read(1'b0, 200, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
